// File: rtl/fatmeshy_pkg.sv
// fatmeshy_pkg: shared link widths, credit type and tx scheduler state/defaults
package fatmeshy_pkg;
   localparam int LINK_WORD_SIZE = 32;
   localparam int CREDIT_WIDTH = 8;
   localparam int MAX_CREDIT_DEFAULT = 16;
   localparam int CTRL_BURST_DEFAULT = 4;
   localparam int STARVE_TIMEOUT_DEFAULT = 64;
   typedef logic [CREDIT_WIDTH-1:0] credit_t;
   typedef enum logic [1:0] {RUN, STARVED, REJECT} tx_sched_state_t;
endpackage

// File: rtl/link_credit_tracker.sv
// link_credit_tracker: downstream credit counter with absolute refresh, clamp and zero floor
module link_credit_tracker
   import fatmeshy_pkg::*;
#(
   parameter int CREDIT_W = CREDIT_WIDTH,
   parameter int MAX_CREDIT = MAX_CREDIT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                credit_valid,
   input  logic [CREDIT_W-1:0] credit_in,
   input  logic                consume,
   output logic [CREDIT_W-1:0] count,
   output logic                has_credit
);
   logic [CREDIT_W-1:0] count_q, count_d, loaded;
   // a refresh replaces the count but still pays for a grant made in the same cycle
   always_comb begin
      loaded = (credit_in > CREDIT_W'(consume)) ? credit_in - CREDIT_W'(consume) : '0;
      count_d = credit_valid ? ((loaded > CREDIT_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT) : loaded)
                             : count_q - CREDIT_W'(consume);
   end
   // credit register
   always_ff @(posedge clk or posedge rst)
      if (rst) count_q <= '0;
      else count_q <= count_d;
   assign count = count_q;
   assign has_credit = count_q != '0;
endmodule

// File: rtl/link_tx_scheduler.sv
// link_tx_scheduler: shares one link word slot between control words and credit-gated ARQ words
module link_tx_scheduler
   import fatmeshy_pkg::*;
#(
   parameter int WORD_W = LINK_WORD_SIZE,
   parameter int CREDIT_W = CREDIT_WIDTH,
   parameter int MAX_CREDIT = MAX_CREDIT_DEFAULT,
   parameter int CTRL_BURST = CTRL_BURST_DEFAULT,
   parameter int STARVE_TIMEOUT = STARVE_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ctrl_valid,
   input  logic [WORD_W-1:0]   ctrl_data,
   output logic                ctrl_ready,
   input  logic                arq_valid,
   input  logic [WORD_W-1:0]   arq_data,
   input  logic                arq_prio,
   output logic                arq_accept,
   output logic                arq_reject,
   input  logic [CREDIT_W-1:0] credit_in,
   input  logic                credit_valid,
   output logic                link_valid,
   output logic [WORD_W-1:0]   link_data,
   input  logic                link_ready,
   output logic [CREDIT_W-1:0] credit_count
);
   localparam int BW = $clog2(CTRL_BURST + 1);
   localparam int SW = $clog2(STARVE_TIMEOUT);
   tx_sched_state_t state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [WORD_W-1:0] link_data_q, link_data_d;
   logic link_valid_q, link_valid_d, arq_reject_q, arq_reject_d;
   logic has_credit, slot_free, arq_can, ctrl_grant, arq_grant;

   link_credit_tracker #(.CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT)) u_credit (
      .clk(clk),
      .rst(rst),
      .credit_valid(credit_valid),
      .credit_in(credit_in),
      .consume(arq_grant),
      .count(credit_count),
      .has_credit(has_credit)
   );

   // arbitration: retransmit first, then control unless its burst quota is spent, then ARQ data
   always_comb begin
      slot_free = !link_valid_q || link_ready;
      arq_can = arq_valid && has_credit && state_q != REJECT;
      ctrl_grant = slot_free && ctrl_valid && !(arq_can && arq_prio) && !(arq_can && burst_q == BW'(CTRL_BURST));
      arq_grant = slot_free && arq_can && !ctrl_grant;
   end

   // next-state: output slot, burst counter and starvation FSM
   always_comb begin
      link_valid_d = (ctrl_grant || arq_grant) || (link_valid_q && !link_ready);
      link_data_d = ctrl_grant ? ctrl_data : arq_grant ? arq_data : link_data_q;
      burst_d = (arq_grant || !arq_valid) ? '0
              : (ctrl_grant && has_credit && burst_q != BW'(CTRL_BURST)) ? burst_q + BW'(1) : burst_q;
      state_d = state_q;
      starve_d = starve_q;
      arq_reject_d = 1'b0;
      case (state_q)
         RUN: if (arq_valid && !has_credit) begin
            state_d = STARVED;
            starve_d = '0;
         end
         STARVED: if (has_credit) state_d = RUN;
         else if (starve_q == SW'(STARVE_TIMEOUT - 1)) begin
            state_d = REJECT;
            arq_reject_d = 1'b1;
         end else starve_d = starve_q + SW'(1);
         default: state_d = RUN;
      endcase
   end

   // state and registered outputs; a word in flight at reset is dropped
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= RUN;
         starve_q <= '0;
         burst_q <= '0;
         link_valid_q <= 1'b0;
         link_data_q <= '0;
         arq_reject_q <= 1'b0;
      end else begin
         state_q <= state_d;
         starve_q <= starve_d;
         burst_q <= burst_d;
         link_valid_q <= link_valid_d;
         link_data_q <= link_data_d;
         arq_reject_q <= arq_reject_d;
      end

   assign ctrl_ready = ctrl_grant;
   assign arq_accept = arq_grant;
   assign arq_reject = arq_reject_q;
   assign link_valid = link_valid_q;
   assign link_data = link_data_q;
endmodule

// File: tb/tb_link_tx_scheduler.sv
// tb_link_tx_scheduler: directed checks of arbitration, credits, starvation reject and stalls
module tb_link_tx_scheduler;
   logic clk = 0, rst = 1;
   logic ctrl_valid = 0, arq_valid = 0, arq_prio = 0, credit_valid = 0, link_ready = 1;
   logic [31:0] ctrl_data = 0, arq_data = 0;
   logic [7:0] credit_in = 0;
   logic ctrl_ready, arq_accept, arq_reject, link_valid;
   logic [31:0] link_data;
   logic [7:0] credit_count;
   int checks = 0, errors = 0;

   link_tx_scheduler dut (
      .clk(clk), .rst(rst),
      .ctrl_valid(ctrl_valid), .ctrl_data(ctrl_data), .ctrl_ready(ctrl_ready),
      .arq_valid(arq_valid), .arq_data(arq_data), .arq_prio(arq_prio),
      .arq_accept(arq_accept), .arq_reject(arq_reject),
      .credit_in(credit_in), .credit_valid(credit_valid),
      .link_valid(link_valid), .link_data(link_data), .link_ready(link_ready),
      .credit_count(credit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      ctrl_valid = 0; arq_valid = 0; arq_prio = 0; credit_valid = 0; link_ready = 1;
      ctrl_data = 0; arq_data = 0; credit_in = 0;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic load_credit(input logic [7:0] n);
      credit_valid = 1;
      credit_in = n;
      tick();
      credit_valid = 0;
   endtask

   initial begin
      do_reset();
      rst = 1;
      #1;
      check("rst_link_valid", 32'(link_valid), 0);
      check("rst_link_data", link_data, 0);
      check("rst_ctrl_ready", 32'(ctrl_ready), 0);
      check("rst_arq_accept", 32'(arq_accept), 0);
      check("rst_arq_reject", 32'(arq_reject), 0);
      check("rst_credit", 32'(credit_count), 0);
      rst = 0;
      tick();

      load_credit(3);
      check("t1_credit_loaded", 32'(credit_count), 3);
      for (int i = 0; i < 5; i++) begin
         arq_valid = 1;
         arq_data = 32'h100 + 32'(i);
         #1;
         check("t1_accept", 32'(arq_accept), 32'(i < 3));
         check("t1_link_valid", 32'(link_valid), 32'(i >= 1 && i <= 3));
         check("t1_credit", 32'(credit_count), 32'(3 - (i < 3 ? i : 3)));
         if (i >= 1 && i <= 3) check("t1_link_data", link_data, 32'h100 + 32'(i - 1));
         tick();
      end
      arq_valid = 0;

      do_reset();
      load_credit(10);
      ctrl_data = 32'hC0DE0001;
      arq_data = 32'hA0A00001;
      for (int i = 0; i < 10; i++) begin
         ctrl_valid = 1;
         arq_valid = 1;
         #1;
         check("t2_ctrl_ready", 32'(ctrl_ready), 32'(i % 5 != 4));
         check("t2_arq_accept", 32'(arq_accept), 32'(i % 5 == 4));
         check("t2_credit", 32'(credit_count), 32'(10 - i / 5));
         if (i == 5) check("t2_link_data_arq", link_data, 32'hA0A00001);
         if (i == 4) check("t2_link_data_ctrl", link_data, 32'hC0DE0001);
         tick();
      end

      do_reset();
      load_credit(1);
      ctrl_valid = 1; ctrl_data = 32'h0000C7C7;
      arq_valid = 1; arq_prio = 1; arq_data = 32'h0000AAAA;
      #1;
      check("t3_prio_accept", 32'(arq_accept), 1);
      check("t3_prio_ctrl_wait", 32'(ctrl_ready), 0);
      tick();
      check("t3_ctrl_next", 32'(ctrl_ready), 1);
      check("t3_no_accept", 32'(arq_accept), 0);
      check("t3_credit_zero", 32'(credit_count), 0);
      check("t3_link_arq", link_data, 32'h0000AAAA);
      tick();
      arq_valid = 0; ctrl_valid = 0;
      check("t3_link_ctrl", link_data, 32'h0000C7C7);

      do_reset();
      for (int i = 0; i < 67; i++) begin
         arq_valid = 1;
         ctrl_valid = 1;
         #1;
         check("t4_reject", 32'(arq_reject), 32'(i == 65));
         check("t4_no_accept", 32'(arq_accept), 0);
         check("t4_ctrl_flows", 32'(ctrl_ready), 1);
         tick();
      end
      arq_valid = 0; ctrl_valid = 0;

      do_reset();
      load_credit(5);
      ctrl_valid = 1; ctrl_data = 32'h5A5A0000;
      tick();
      link_ready = 0;
      arq_valid = 1;
      ctrl_data = 32'h11111111;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("t5_hold_data", link_data, 32'h5A5A0000);
         check("t5_hold_valid", 32'(link_valid), 1);
         check("t5_no_ctrl", 32'(ctrl_ready), 0);
         check("t5_no_arq", 32'(arq_accept), 0);
         tick();
      end
      link_ready = 1;
      for (int j = 0; j < 3; j++) begin
         ctrl_data = 32'h200 + 32'(j);
         #1;
         check("t5_resume_ctrl", 32'(ctrl_ready), 1);
         tick();
         check("t5_resume_data", link_data, 32'h200 + 32'(j));
      end
      ctrl_valid = 0; arq_valid = 0;

      do_reset();
      load_credit(1);
      arq_valid = 1;
      credit_valid = 1;
      credit_in = 200;
      #1;
      check("t6_accept_clamp", 32'(arq_accept), 1);
      tick();
      check("t6_clamped", 32'(credit_count), 16);
      credit_in = 0;
      #1;
      check("t6_accept_floor", 32'(arq_accept), 1);
      tick();
      credit_valid = 0;
      arq_valid = 0;
      check("t6_floored", 32'(credit_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
